hazard_scheduler: RTL and testbench

- Pipeline hazard and stall scheduler for the 5-stage RV core (F/D/E/M/W); sits beside the Controller and drives the pipeline-register enables and flushes.
- Resolves data hazards with forwarding or a load-use stall, and control hazards with flushes on a taken branch or jump.
- Sequences variable-latency data-memory accesses through a req/ack wait FSM with timeout.
- Its Flush_E output feeds the Controller's Flush_E input.

---
 rtl/hazard_scheduler_pkg.sv | 29 ++
 rtl/hazard_scheduler_mem_wait_fsm.sv | 52 +++++
 rtl/hazard_scheduler.sv | 102 ++++++++++
 tb/tb_hazard_scheduler.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_scheduler_pkg.sv
// rtl/hazard_scheduler_pkg.sv - shared forward-select constants, FSM states and forwarding helper
package hazard_defs;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_W    = 2'b01;
    localparam logic [1:0] FWD_M    = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    // M beats W because it holds the younger result for the same register.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic       reg_write_m,
        input logic [4:0] rd_m,
        input logic       reg_write_w,
        input logic [4:0] rd_w
    );
        if (reg_write_m && rd_m != 5'd0 && rd_m == rs)
            return FWD_M;
        else if (reg_write_w && rd_w != 5'd0 && rd_w == rs)
            return FWD_W;
        return FWD_NONE;
    endfunction

endpackage

// File: rtl/hazard_scheduler_mem_wait_fsm.sv
// rtl/hazard_scheduler_mem_wait_fsm.sv - data-memory req/ack wait sequencer with timeout and sticky error
import hazard_defs::*;

module mem_wait_fsm #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic mem_req,
    input  logic mem_ack,
    output logic mem_stall,
    output logic mem_err
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    state_t        state;
    logic [CW-1:0] cnt;

    // cnt holds the number of stall cycles already spent on the current access.
    assign mem_stall = rst_n && mem_req && !mem_ack && (state != ST_ERR);
    assign mem_err   = (state == ST_ERR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mem_req && !mem_ack) begin
                        cnt   <= CW'(1);
                        state <= (MEM_TIMEOUT == 1) ? ST_ERR : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_ack || !mem_req) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else if (cnt + CW'(1) == CW'(MEM_TIMEOUT)) begin
                        state <= ST_ERR;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_ERR:  state <= ST_ERR;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/hazard_scheduler.sv
// rtl/hazard_scheduler.sv - 5-stage pipeline hazard/stall scheduler; optional perf counters via HAZ_PERF_CNT_EN
import hazard_defs::*;

module hazard_scheduler #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [4:0]       Rs1_D,
    input  logic [4:0]       Rs2_D,
    input  logic [4:0]       Rs1_E,
    input  logic [4:0]       Rs2_E,
    input  logic [4:0]       Rd_E,
    input  logic [4:0]       Rd_M,
    input  logic [4:0]       Rd_W,
    input  logic             RegWrite_M,
    input  logic             RegWrite_W,
    input  logic             Result_Src_0,
    input  logic             PCSrc_E,
    input  logic             MemReq_M,
    input  logic             MemAck,
    output logic             Stall_F,
    output logic             Stall_D,
    output logic             Stall_E,
    output logic             Stall_M,
    output logic             Flush_D,
    output logic             Flush_E,
    output logic             Flush_W,
    output logic [1:0]       Forward_A_E,
    output logic [1:0]       Forward_B_E,
    output logic             Mem_Err,
    output logic [CNT_W-1:0] Perf_Stall_Cnt,
    output logic [CNT_W-1:0] Perf_Flush_Cnt
);

    logic mem_stall;
    logic lw_stall;

    mem_wait_fsm #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_mem_wait (
        .clk       (Clk),
        .rst_n     (Reset),
        .mem_req   (MemReq_M),
        .mem_ack   (MemAck),
        .mem_stall (mem_stall),
        .mem_err   (Mem_Err)
    );

    assign Forward_A_E = fwd_sel(Rs1_E, RegWrite_M, Rd_M, RegWrite_W, Rd_W);
    assign Forward_B_E = fwd_sel(Rs2_E, RegWrite_M, Rd_M, RegWrite_W, Rd_W);

    assign lw_stall = Result_Src_0 && (Rd_E != 5'd0) && ((Rd_E == Rs1_D) || (Rd_E == Rs2_D));

    // A memory stall freezes E, so a taken branch there waits and flushes after release.
    always_comb begin
        Stall_F = 1'b0;
        Stall_D = 1'b0;
        Stall_E = 1'b0;
        Stall_M = 1'b0;
        Flush_D = 1'b0;
        Flush_E = 1'b0;
        Flush_W = 1'b0;
        if (mem_stall) begin
            Stall_F = 1'b1;
            Stall_D = 1'b1;
            Stall_E = 1'b1;
            Stall_M = 1'b1;
            Flush_W = 1'b1;
        end else if (Reset && PCSrc_E) begin
            Flush_D = 1'b1;
            Flush_E = 1'b1;
        end else if (Reset && lw_stall) begin
            Stall_F = 1'b1;
            Stall_D = 1'b1;
            Flush_E = 1'b1;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if ((Stall_F || Stall_D || Stall_E || Stall_M) && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if ((Flush_D || Flush_E) && flush_cnt != '1)
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    assign Perf_Stall_Cnt = stall_cnt;
    assign Perf_Flush_Cnt = flush_cnt;
`else
    assign Perf_Stall_Cnt = '0;
    assign Perf_Flush_Cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_scheduler.sv
// tb/tb_hazard_scheduler.sv - directed plus random self-checking bench for hazard_scheduler
module tb_hazard_scheduler;

    localparam int TO = 4;
    localparam int CW = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          Clk = 1'b0;
    logic          Reset;
    logic [4:0]    Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W;
    logic          RegWrite_M, RegWrite_W, Result_Src_0, PCSrc_E, MemReq_M, MemAck;
    logic          Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Flush_W;
    logic [1:0]    Forward_A_E, Forward_B_E;
    logic          Mem_Err;
    logic [CW-1:0] Perf_Stall_Cnt, Perf_Flush_Cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state: stalls spent on the current access, sticky error, counters.
    int waited = 0;
    bit err_m  = 1'b0;
    int pstall = 0;
    int pflush = 0;

    hazard_scheduler #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .Clk(Clk), .Reset(Reset),
        .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E), .Rd_E(Rd_E),
        .Rd_M(Rd_M), .Rd_W(Rd_W), .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
        .Result_Src_0(Result_Src_0), .PCSrc_E(PCSrc_E), .MemReq_M(MemReq_M), .MemAck(MemAck),
        .Stall_F(Stall_F), .Stall_D(Stall_D), .Stall_E(Stall_E), .Stall_M(Stall_M),
        .Flush_D(Flush_D), .Flush_E(Flush_E), .Flush_W(Flush_W),
        .Forward_A_E(Forward_A_E), .Forward_B_E(Forward_B_E), .Mem_Err(Mem_Err),
        .Perf_Stall_Cnt(Perf_Stall_Cnt), .Perf_Flush_Cnt(Perf_Flush_Cnt)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (RegWrite_M && Rd_M != 0 && Rd_M == rs) return 2'b10;
        if (RegWrite_W && Rd_W != 0 && Rd_W == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic clear_inputs();
        {Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W} = '0;
        {RegWrite_M, RegWrite_W, Result_Src_0, PCSrc_E, MemReq_M, MemAck} = '0;
    endtask

    task automatic check_now(input string tag);
        bit mem, br, lw, sf, sem, fd, fe, fw;
        int exp_ps, exp_pf;
        mem = Reset && MemReq_M && !MemAck && !err_m;
        br  = Reset && !mem && PCSrc_E;
        lw  = Reset && !mem && !PCSrc_E && Result_Src_0 && Rd_E != 0 &&
              (Rd_E == Rs1_D || Rd_E == Rs2_D);
        sf  = mem || lw;
        sem = mem;
        fd  = br;
        fe  = br || lw;
        fw  = mem;
`ifdef HAZ_PERF_CNT_EN
        exp_ps = pstall;
        exp_pf = pflush;
`else
        exp_ps = 0;
        exp_pf = 0;
`endif
        chk({tag, ".stall_f"}, 32'(Stall_F), 32'(sf));
        chk({tag, ".stall_d"}, 32'(Stall_D), 32'(sf));
        chk({tag, ".stall_e"}, 32'(Stall_E), 32'(sem));
        chk({tag, ".stall_m"}, 32'(Stall_M), 32'(sem));
        chk({tag, ".flush_d"}, 32'(Flush_D), 32'(fd));
        chk({tag, ".flush_e"}, 32'(Flush_E), 32'(fe));
        chk({tag, ".flush_w"}, 32'(Flush_W), 32'(fw));
        chk({tag, ".fwd_a"},   32'(Forward_A_E), 32'(ref_fwd(Rs1_E)));
        chk({tag, ".fwd_b"},   32'(Forward_B_E), 32'(ref_fwd(Rs2_E)));
        chk({tag, ".mem_err"}, 32'(Mem_Err), 32'(err_m));
        chk({tag, ".perf_stall"}, 32'(Perf_Stall_Cnt), 32'(exp_ps));
        chk({tag, ".perf_flush"}, 32'(Perf_Flush_Cnt), 32'(exp_pf));
    endtask

    // Inputs are stable from #1 after a rising edge; outputs checked at the falling edge.
    task automatic step(input string tag);
        bit any_stall, any_flush, mem;
        @(negedge Clk);
        check_now(tag);
        mem       = Reset && MemReq_M && !MemAck && !err_m;
        any_stall = mem || (Reset && !PCSrc_E && Result_Src_0 && Rd_E != 0 &&
                            (Rd_E == Rs1_D || Rd_E == Rs2_D));
        any_flush = Reset && !mem && (PCSrc_E || any_stall);
        @(posedge Clk);
        if (Reset) begin
            if (mem) begin
                waited++;
                if (waited >= TO) err_m = 1'b1;
            end else begin
                waited = 0;
            end
            if (any_stall && pstall < CNT_MAX) pstall++;
            if (any_flush && pflush < CNT_MAX) pflush++;
        end
        #1;
    endtask

    task automatic do_reset(input string tag);
        Reset = 1'b0;
        #1;
        waited = 0;
        err_m  = 1'b0;
        pstall = 0;
        pflush = 0;
        check_now(tag);
        @(posedge Clk);
        #1;
        Reset = 1'b1;
    endtask

    initial begin
        clear_inputs();
        Reset = 1'b0;
        @(posedge Clk);
        #1;
        do_reset("reset");

        Rs1_E = 5; Rd_M = 5; RegWrite_M = 1; Rd_W = 5; RegWrite_W = 1;
        step("fwd_m_prio");
        chk("fwd_m_prio.const", 32'(Forward_A_E), 32'h2);
        RegWrite_M = 0;
        step("fwd_w");
        chk("fwd_w.const", 32'(Forward_A_E), 32'h1);
        RegWrite_M = 1; Rd_M = 0; Rs1_E = 0; Rd_W = 0;
        step("fwd_rd0");
        chk("fwd_rd0.const", 32'(Forward_A_E), 32'h0);

        clear_inputs();
        Result_Src_0 = 1; Rd_E = 7; Rs2_D = 7;
        step("load_use");
        clear_inputs();
        Rd_W = 7; RegWrite_W = 1; Rs2_E = 7;
        step("load_fwd_w");
        chk("load_fwd_w.const", 32'(Forward_B_E), 32'h1);

        clear_inputs();
        PCSrc_E = 1; Result_Src_0 = 1; Rd_E = 3; Rs1_D = 3;
        step("branch_lw");

        clear_inputs();
        MemReq_M = 1; PCSrc_E = 1;
        for (int i = 0; i < 3; i++) step("mem_wait");
        MemAck = 1;
        step("mem_ack");
        clear_inputs();
        step("mem_idle");

        for (int i = 0; i < 400; i++) begin
            Rs1_D = 5'($urandom_range(0, 3)); Rs2_D = 5'($urandom_range(0, 3));
            Rs1_E = 5'($urandom_range(0, 3)); Rs2_E = 5'($urandom_range(0, 3));
            Rd_E  = 5'($urandom_range(0, 3)); Rd_M  = 5'($urandom_range(0, 3));
            Rd_W  = 5'($urandom_range(0, 3));
            RegWrite_M = 1'($urandom); RegWrite_W = 1'($urandom);
            Result_Src_0 = 1'($urandom); PCSrc_E = ($urandom_range(0, 3) == 0);
            MemReq_M = ($urandom_range(0, 2) == 0); MemAck = ($urandom_range(0, 1) == 0);
            step("random");
            if (i == 200) begin
                clear_inputs();
                do_reset("random_reset");
            end
        end

        clear_inputs();
        do_reset("pre_perf");
        Result_Src_0 = 1; Rd_E = 9; Rs1_D = 9;
        for (int i = 0; i < 20; i++) step("perf_stall");
`ifdef HAZ_PERF_CNT_EN
        chk("perf_sat", 32'(Perf_Stall_Cnt), 32'hF);
`else
        chk("perf_off", 32'(Perf_Stall_Cnt), 32'h0);
`endif

        clear_inputs();
        do_reset("pre_timeout");
        MemReq_M = 1;
        for (int i = 0; i < 6; i++) step("timeout");
        chk("timeout.err", 32'(Mem_Err), 32'h1);
        chk("timeout.no_stall", 32'(Stall_F), 32'h0);

        clear_inputs();
        do_reset("pre_midwait");
        MemReq_M = 1;
        step("midwait");
        step("midwait");
        do_reset("midwait_reset");
        chk("midwait.err", 32'(Mem_Err), 32'h0);
        clear_inputs();
        step("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
